// File: rtl/pipe_rpt_pkg.sv
// Shared types and helpers for the elastic repeater chain.
// Stage state encoding, the stage-count ceiling and the occupancy-width rule.
package pipe_rpt_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } stage_state_e;

   localparam int MAX_STAGES = 8;

   // Counter must represent 0..2*stages inclusive.
   function automatic int occ_width(input int stages);
      return $clog2(2 * stages + 1);
   endfunction

endpackage

// File: rtl/rpt_skid_stage.sv
// One registered repeater stage: a two-entry skid buffer (main M, skid S).
// Both up_ready and dn_valid are registered, so no combinational path crosses it.
module rpt_skid_stage
   import pipe_rpt_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [WIDTH-1:0] up_data,
   output logic             dn_valid,
   input  logic             dn_ready,
   output logic [WIDTH-1:0] dn_data
);

   stage_state_e     state_reg, state_next;
   logic [WIDTH-1:0] m_reg, m_next;
   logic [WIDTH-1:0] s_reg, s_next;
   logic             ready_reg;
   logic             valid_reg;
   logic             up_fire;
   logic             dn_fire;

   assign up_ready = ready_reg;
   assign dn_valid = valid_reg;
   assign dn_data  = m_reg;

   always_comb begin
      up_fire    = up_valid & ready_reg;
      dn_fire    = valid_reg & dn_ready;
      state_next = state_reg;
      m_next     = m_reg;
      s_next     = s_reg;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (up_fire) begin
                  state_next = HALF;
                  m_next     = up_data;
               end
            end
            HALF: begin
               if (up_fire && dn_fire) begin
                  m_next = up_data;
               end else if (up_fire) begin
                  state_next = FULL;
                  s_next     = up_data;
               end else if (dn_fire) begin
                  state_next = EMPTY;
               end
            end
            FULL: begin
               if (dn_fire) begin
                  state_next = HALF;
                  m_next     = s_reg;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   // Handshake flags are decoded from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= EMPTY;
         m_reg     <= '0;
         s_reg     <= '0;
         ready_reg <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         m_reg     <= m_next;
         s_reg     <= s_next;
         ready_reg <= (state_next != FULL);
         valid_reg <= (state_next != EMPTY);
      end
   end

endmodule

// File: rtl/pipe_repeater_buf.sv
// Elastic, parametrised repeater chain: STAGES skid stages with per-bit polarity
// applied once at entry, plus a registered occupancy counter and flush fan-out.
module pipe_repeater_buf
   import pipe_rpt_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter int               STAGES   = 2,
   parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b0}},
   parameter int               CNT_W    = occ_width(STAGES)
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   output logic [CNT_W-1:0] occupancy
);

   logic             chain_valid [STAGES+1];
   logic             chain_ready [STAGES+1];
   logic [WIDTH-1:0] chain_data  [STAGES+1];

   logic [CNT_W-1:0] occ_reg, occ_next;
   logic             in_fire;
   logic             out_fire;

   assign chain_valid[0]      = in_valid;
   assign chain_data[0]       = in_data ^ INV_MASK;
   assign in_ready            = chain_ready[0];
   assign out_valid           = chain_valid[STAGES];
   assign out_data            = chain_data[STAGES];
   assign chain_ready[STAGES] = out_ready;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         rpt_skid_stage #(
            .WIDTH (WIDTH)
         ) u_stage (
            .clk      (CLK),
            .rst_n    (RESETN),
            .flush    (flush),
            .up_valid (chain_valid[gi]),
            .up_ready (chain_ready[gi]),
            .up_data  (chain_data[gi]),
            .dn_valid (chain_valid[gi+1]),
            .dn_ready (chain_ready[gi+1]),
            .dn_data  (chain_data[gi+1])
         );
      end
   endgenerate

   assign occupancy = occ_reg;

   // Bounded by the stage capacity, so the counter can never wrap.
   always_comb begin
      in_fire  = in_valid & in_ready;
      out_fire = out_valid & out_ready;
      occ_next = occ_reg;
      if (flush) begin
         occ_next = '0;
      end else if (in_fire && !out_fire) begin
         occ_next = occ_reg + CNT_W'(1);
      end else if (out_fire && !in_fire) begin
         occ_next = occ_reg - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         occ_reg <= '0;
      end else begin
         occ_reg <= occ_next;
      end
   end

endmodule
